// File: rtl/clock_pkg.sv
// Shared calendar-chain definitions: field widths, month numbering and month lengths.
// Used by the day/month counters and the month-length lookup.
package clock_pkg;

    localparam int DAY_W    = 5;
    localparam int MONTH_W  = 4;
    localparam int FEB_DAYS = 28;
    localparam int DAYS_31  = 31;
    localparam int DAYS_30  = 30;

    typedef enum logic [MONTH_W-1:0] {
        JAN = 4'd1,
        FEB = 4'd2,
        MAR = 4'd3,
        APR = 4'd4,
        MAY = 4'd5,
        JUN = 4'd6,
        JUL = 4'd7,
        AUG = 4'd8,
        SEP = 4'd9,
        OCT = 4'd10,
        NOV = 4'd11,
        DEC = 4'd12
    } month_e;

endpackage

// File: rtl/day_counter_if.sv
// Signal bundle between the calendar controller and the day-of-month counter.
// master drives the controls and month context; slave is the counter itself.
interface day_counter_if #(
    parameter int DAY_W = clock_pkg::DAY_W
);
    import clock_pkg::*;

    logic               inc;
    logic               dec;
    logic               ctrl_set;
    logic               carry_in_hour;
    logic [MONTH_W-1:0] month_count;
    logic               leap_year;
    logic [DAY_W-1:0]   day_count;
    logic [DAY_W-1:0]   max_day;
    logic               carry_out;

    modport master (
        output inc, dec, ctrl_set, carry_in_hour, month_count, leap_year,
        input  day_count, max_day, carry_out
    );

    modport slave (
        input  inc, dec, ctrl_set, carry_in_hour, month_count, leap_year,
        output day_count, max_day, carry_out
    );

endinterface

// File: rtl/day_counter_days_in_month.sv
// Month length lookup: month number and leap flag to number of days.
// Out-of-range month numbers read as a 31-day month.
module days_in_month
    import clock_pkg::*;
#(
    parameter int DAY_W    = clock_pkg::DAY_W,
    parameter int FEB_DAYS = clock_pkg::FEB_DAYS
) (
    input  logic [MONTH_W-1:0] month_i,
    input  logic               leap_i,
    output logic [DAY_W-1:0]   max_day_o
);

    always_comb begin
        max_day_o = DAY_W'(DAYS_31);
        case (month_i)
            FEB:                max_day_o = DAY_W'(FEB_DAYS) + DAY_W'(leap_i);
            APR, JUN, SEP, NOV: max_day_o = DAY_W'(DAYS_30);
            default:            max_day_o = DAY_W'(DAYS_31);
        endcase
    end

endmodule

// File: rtl/day_counter.sv
// Day-of-month counter: advances on the time-of-day carry, steps in set mode,
// and pulls the day back into range when the month shrinks under it.
module day_counter
    import clock_pkg::*;
#(
    parameter int DAY_W    = clock_pkg::DAY_W,
    parameter int FEB_DAYS = clock_pkg::FEB_DAYS
) (
    input logic         clk,
    input logic         rst_n,
    day_counter_if.slave bus
);

    logic [DAY_W-1:0] day_q;
    logic [DAY_W-1:0] day_d;
    logic [DAY_W-1:0] max_day;
    logic             at_end;

    days_in_month #(
        .DAY_W    (DAY_W),
        .FEB_DAYS (FEB_DAYS)
    ) u_days_in_month (
        .month_i   (bus.month_count),
        .leap_i    (bus.leap_year),
        .max_day_o (max_day)
    );

    // >= rather than == so an over-range day wraps instead of counting past 31
    assign at_end = (day_q >= max_day);

    always_comb begin
        day_d = day_q;
        if (bus.ctrl_set && bus.inc) begin
            day_d = at_end ? DAY_W'(1) : day_q + DAY_W'(1);
        end else if (bus.ctrl_set && bus.dec) begin
            day_d = (day_q == DAY_W'(1)) ? max_day : day_q - DAY_W'(1);
        end else if (!bus.ctrl_set && bus.carry_in_hour) begin
            day_d = at_end ? DAY_W'(1) : day_q + DAY_W'(1);
        end else if (day_q > max_day) begin
            day_d = max_day;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_q <= DAY_W'(1);
        end else begin
            day_q <= day_d;
        end
    end

    assign bus.day_count = day_q;
    assign bus.max_day   = max_day;
    assign bus.carry_out = bus.carry_in_hour && !bus.ctrl_set && at_end;

endmodule

// File: tb/tb_day_counter.sv
// Directed bench for day_counter: a calendar-level model checked every cycle,
// plus hand-computed checkpoints along the scripted scenarios.
module tb_day_counter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int total = 0;
    int bad   = 0;

    int modelDay = 1;
    int lenTable [16] = '{31, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31, 31, 31, 31};

    day_counter_if #(.DAY_W(5)) dutIf ();

    day_counter #(
        .DAY_W    (5),
        .FEB_DAYS (28)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dutIf)
    );

    initial forever #5 clk = ~clk;

    function automatic int monthLen(input logic [3:0] m, input logic lp);
        return lenTable[m] + ((m == 4'd2) ? int'(lp) : 0);
    endfunction

    // Calendar model: what tomorrow is, given today and the controls seen at the edge
    always @(posedge clk or negedge rst_n) begin
        int len;
        if (!rst_n) begin
            modelDay = 1;
        end else begin
            len = monthLen(dutIf.month_count, dutIf.leap_year);
            if (dutIf.ctrl_set && dutIf.inc)
                modelDay = (modelDay >= len) ? 1 : modelDay + 1;
            else if (dutIf.ctrl_set && dutIf.dec)
                modelDay = (modelDay == 1) ? len : modelDay - 1;
            else if (!dutIf.ctrl_set && dutIf.carry_in_hour)
                modelDay = (modelDay >= len) ? 1 : modelDay + 1;
            else if (modelDay > len)
                modelDay = len;
        end
    end

    always @(negedge clk) begin
        int  len;
        bit  expCarry;
        len      = monthLen(dutIf.month_count, dutIf.leap_year);
        expCarry = dutIf.carry_in_hour && !dutIf.ctrl_set && (modelDay >= len);
        total++;
        if (dutIf.day_count !== 5'(modelDay)) begin
            bad++;
            $display("[TB] FAIL model_day t=%0t: got %0d, want %0d", $time, dutIf.day_count, modelDay);
        end
        total++;
        if (dutIf.max_day !== 5'(len)) begin
            bad++;
            $display("[TB] FAIL model_max t=%0t: got %0d, want %0d", $time, dutIf.max_day, len);
        end
        total++;
        if (dutIf.carry_out !== expCarry) begin
            bad++;
            $display("[TB] FAIL model_carry t=%0t: got %0b, want %0b", $time, dutIf.carry_out, expCarry);
        end
    end

    task automatic applyStimulus(input bit incV, input bit decV, input bit setV,
                                 input bit carryV, input int monthV, input bit leapV);
        dutIf.inc           = incV;
        dutIf.dec           = decV;
        dutIf.ctrl_set      = setV;
        dutIf.carry_in_hour = carryV;
        dutIf.month_count   = 4'(monthV);
        dutIf.leap_year     = leapV;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int expDay, input bit expCarry);
        total++;
        if (dutIf.day_count !== 5'(expDay) || dutIf.carry_out !== expCarry) begin
            bad++;
            $display("[TB] FAIL %s: got day=%0d carry=%0b, want day=%0d carry=%0b",
                     name, dutIf.day_count, dutIf.carry_out, expDay, expCarry);
        end
    endtask

    task automatic checkMax(input string name, input int expMax);
        total++;
        if (dutIf.max_day !== 5'(expMax)) begin
            bad++;
            $display("[TB] FAIL %s: got max_day=%0d, want %0d", name, dutIf.max_day, expMax);
        end
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 1, 0);
        rst_n = 1'b0;
        #2;
        checkOutput("reset_state", 1, 0);
        #9;
        rst_n = 1'b1;
        tick();

        // January: 30 hour carries walk 1 -> 31, the 31st wraps with a carry
        for (int i = 0; i < 30; i++) begin
            applyStimulus(0, 0, 0, 1, 1, 0);
            checkOutput("jan_walk", i + 1, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("jan_day31", 31, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        checkOutput("jan_carry", 31, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("jan_wrapped", 1, 0);

        // February non-leap then leap
        for (int i = 0; i < 27; i++) begin
            applyStimulus(0, 0, 0, 1, 2, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 1, 2, 0);
        checkOutput("feb28_carry", 28, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 2, 1);
        checkOutput("feb_wrapped", 1, 0);
        checkMax("feb_leap_max", 29);
        for (int i = 0; i < 27; i++) begin
            applyStimulus(0, 0, 0, 1, 2, 1);
            tick();
        end
        applyStimulus(0, 0, 0, 1, 2, 1);
        checkOutput("leap28_nocarry", 28, 0);
        tick();
        checkOutput("leap_day29", 29, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 2, 1);
        checkOutput("leap_wrapped", 1, 0);

        // Set mode in April, hour carry held high and ignored
        applyStimulus(0, 1, 1, 1, 4, 0);
        checkOutput("set_dec_pre", 1, 0);
        tick();
        applyStimulus(1, 0, 1, 1, 4, 0);
        checkOutput("set_dec_wrap", 30, 0);
        tick();
        checkOutput("set_inc_wrap", 1, 0);
        tick();
        applyStimulus(1, 1, 1, 1, 4, 0);
        checkOutput("set_inc", 2, 0);
        tick();
        checkOutput("set_inc_dec", 3, 0);

        // Clamp when the month shrinks under the current day
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 0, 1, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 4, 0);
        checkOutput("clamp_apr_pre", 31, 0);
        checkMax("apr_max", 30);
        tick();
        checkOutput("clamp_apr", 30, 0);
        applyStimulus(1, 0, 1, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 2, 0);
        checkOutput("clamp_feb_pre", 31, 0);
        tick();
        checkOutput("clamp_feb", 28, 0);

        // December 31: carry ignored in set mode, honoured after
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, 0, 12, 0);
            tick();
        end
        applyStimulus(0, 0, 1, 1, 12, 0);
        checkOutput("dec31_set_carry", 31, 0);
        tick();
        checkOutput("dec31_held", 31, 0);
        applyStimulus(0, 0, 0, 1, 12, 0);
        checkOutput("dec31_run_carry", 31, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 12, 0);
        checkOutput("dec31_wrapped", 1, 0);

        // Asynchronous reset mid-cycle at day 17 with inc held
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0, 1, 12, 0);
            tick();
        end
        applyStimulus(1, 0, 1, 0, 12, 0);
        checkOutput("pre_reset_day17", 17, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 1, 0);
        tick();
        checkOutput("reset_held", 1, 0);
        #2;
        rst_n = 1'b1;
        tick();
        checkOutput("post_reset_inc", 2, 0);
        applyStimulus(0, 0, 0, 1, 12, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 12, 0);
        checkOutput("post_reset_carry", 3, 0);

        // Month-length table including illegal month numbers
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkMax("month0_max", 31);
        applyStimulus(0, 0, 0, 0, 13, 0);
        checkMax("month13_max", 31);
        applyStimulus(0, 0, 0, 0, 9, 0);
        checkMax("sep_max", 30);
        applyStimulus(0, 0, 0, 0, 2, 0);
        checkMax("feb_max", 28);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
